// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl -- sequencing controller for the PC update unit.
//
// Each cycle it arbitrates, highest priority first, between a datapath stall,
// an illegal-opcode trap, an external interrupt and normal instruction flow.
// It drives the PC source select, squashes the current instruction on a trap,
// writes the exception return address into $26, and tracks handler mode so
// that nested interrupts are masked.
//
// Parameters:
//   IRQ_EDGE : 1 = rising-edge triggered interrupt latched as pending,
//              0 = level triggered (pending follows the synchronised level)
//   CNT_W    : width of the saturating trap counter
//
// Ports:
//   clk           clock
//   reset         synchronous, active-low reset
//   i_stall       datapath wait; hold the PC this cycle
//   i_instr_class decoded class: 0 SEQ, 1 BRANCH, 2 JUMP, 3 JR, 7 ILLEGAL
//   i_jr_tgt_k    bit 31 of the JR target register
//   i_pc          current PC
//   i_irq         asynchronous external interrupt request
//   o_pc_src      000 plus4, 001 branch, 010 jump, 011 jr, 100 ILLOP,
//                 101 XADR, 111 hold
//   o_squash      suppress register/memory writes of the current instruction
//   o_epc_we      write o_epc into $26 at this clock edge
//   o_epc         exception return address
//   o_irq_ack     one-cycle pulse when an interrupt is taken
//   o_in_handler  controller is in handler mode
//   o_dbl_fault   sticky: illegal opcode taken while in handler mode
//   o_trap_cnt    saturating count of taken traps
module pc_seq_ctrl #(
  parameter int IRQ_EDGE = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_stall,
  input  logic [2:0]       i_instr_class,
  input  logic             i_jr_tgt_k,
  input  logic [31:0]      i_pc,
  input  logic             i_irq,
  output logic [2:0]       o_pc_src,
  output logic             o_squash,
  output logic             o_epc_we,
  output logic [31:0]      o_epc,
  output logic             o_irq_ack,
  output logic             o_in_handler,
  output logic             o_dbl_fault,
  output logic [CNT_W-1:0] o_trap_cnt
);

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_HANDLER = 1'b1
  } state_t;

  localparam logic [2:0] CLS_BRANCH  = 3'd1;
  localparam logic [2:0] CLS_JUMP    = 3'd2;
  localparam logic [2:0] CLS_JR      = 3'd3;
  localparam logic [2:0] CLS_ILLEGAL = 3'd7;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_irq_meta;
  logic             r_irq_s;
  logic             w_pend;
  logic             w_irq_ok;
  logic             w_take_ill;
  logic             w_take_irq;
  logic             w_take_trap;
  logic             r_dbl_fault;
  logic [CNT_W-1:0] r_trap_cnt;

  // Two-flop synchroniser for the asynchronous request; runs even during stall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_irq_meta <= 1'b0;
      r_irq_s    <= 1'b0;
    end else begin
      r_irq_meta <= i_irq;
      r_irq_s    <= r_irq_meta;
    end
  end

  generate
    if (IRQ_EDGE != 0) begin : g_edge
      logic r_irq_s_d;
      logic r_pend;
      // A rise arriving in the same cycle as a take keeps the request pending.
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_irq_s_d <= 1'b0;
          r_pend    <= 1'b0;
        end else begin
          r_irq_s_d <= r_irq_s;
          r_pend    <= (r_pend & ~w_take_irq) | (r_irq_s & ~r_irq_s_d);
        end
      end
      assign w_pend = r_pend;
    end else begin : g_level
      assign w_pend = r_irq_s;
    end
  endgenerate

  // Interrupts are refused in kernel space (pc[31]) and in handler mode,
  // and are never taken while reset is held.
  assign w_irq_ok    = w_pend & ~i_pc[31] & (r_state == ST_NORMAL) & reset;
  assign w_take_ill  = ~i_stall & (i_instr_class == CLS_ILLEGAL);
  assign w_take_irq  = ~i_stall & ~w_take_ill & w_irq_ok;
  assign w_take_trap = w_take_ill | w_take_irq;

  always_comb begin
    o_pc_src     = 3'b000;
    o_squash     = 1'b0;
    o_epc_we     = 1'b0;
    o_epc        = i_pc;
    o_irq_ack    = 1'b0;
    w_state_next = r_state;
    if (i_stall) begin
      o_pc_src = 3'b111;
    end else if (w_take_ill) begin
      o_pc_src     = 3'b100;
      o_squash     = 1'b1;
      o_epc_we     = 1'b1;
      // The supervisor bit is preserved; only the low 31 bits wrap.
      o_epc        = {i_pc[31], i_pc[30:0] + 31'd4};
      w_state_next = ST_HANDLER;
    end else if (w_take_irq) begin
      o_pc_src     = 3'b101;
      o_squash     = 1'b1;
      o_epc_we     = 1'b1;
      o_epc        = i_pc;  // interrupted instruction re-executes on return
      o_irq_ack    = 1'b1;
      w_state_next = ST_HANDLER;
    end else begin
      case (i_instr_class)
        CLS_BRANCH: o_pc_src = 3'b001;
        CLS_JUMP:   o_pc_src = 3'b010;
        CLS_JR:     o_pc_src = 3'b011;
        default:    o_pc_src = 3'b000;
      endcase
      // JR to a user-space target ends the handler.
      if (r_state == ST_HANDLER && i_instr_class == CLS_JR && !i_jr_tgt_k)
        w_state_next = ST_NORMAL;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_NORMAL;
      r_dbl_fault <= 1'b0;
      r_trap_cnt  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_take_ill && r_state == ST_HANDLER)
        r_dbl_fault <= 1'b1;
      if (w_take_trap && !(&r_trap_cnt))
        r_trap_cnt <= r_trap_cnt + 1'b1;
    end
  end

  assign o_in_handler = (r_state == ST_HANDLER);
  assign o_dbl_fault  = r_dbl_fault;
  assign o_trap_cnt   = r_trap_cnt;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: an edge-mode instance (16-bit counter) and a
// level-mode instance (2-bit counter) share the stimulus; each vector names
// which instance it checks. Vectors are pushed to a scoreboard when driven
// and popped and compared on the following falling edge.
module tb_pc_seq_ctrl;

  localparam logic [2:0] SEQ = 3'd0, BR = 3'd1, JMP = 3'd2, JR = 3'd3, OTH = 3'd5, ILL = 3'd7;

  typedef struct {
    logic        lvl;
    logic        rst;
    logic        stall;
    logic [2:0]  cls;
    logic        k;
    logic [31:0] pc;
    logic        irq;
    logic [2:0]  src;
    logic        sq;
    logic        we;
    logic [31:0] epc;
    logic        ack;
    logic        inh;
    logic        dbl;
    logic [15:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  cls = 3'd0;
  logic        k = 1'b0;
  logic [31:0] pc = 32'd0;
  logic        irq = 1'b0;

  logic [2:0]  e_src, l_src;
  logic        e_sq, e_we, e_ack, e_inh, e_dbl;
  logic        l_sq, l_we, l_ack, l_inh, l_dbl;
  logic [31:0] e_epc, l_epc;
  logic [15:0] e_cnt;
  logic [1:0]  l_cnt;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   n_idx = 0;

  always #5 clk = ~clk;

  pc_seq_ctrl #(.IRQ_EDGE(1), .CNT_W(16)) dut_e (
    .clk(clk), .reset(reset), .i_stall(stall), .i_instr_class(cls),
    .i_jr_tgt_k(k), .i_pc(pc), .i_irq(irq),
    .o_pc_src(e_src), .o_squash(e_sq), .o_epc_we(e_we), .o_epc(e_epc),
    .o_irq_ack(e_ack), .o_in_handler(e_inh), .o_dbl_fault(e_dbl), .o_trap_cnt(e_cnt)
  );

  pc_seq_ctrl #(.IRQ_EDGE(0), .CNT_W(2)) dut_l (
    .clk(clk), .reset(reset), .i_stall(stall), .i_instr_class(cls),
    .i_jr_tgt_k(k), .i_pc(pc), .i_irq(irq),
    .o_pc_src(l_src), .o_squash(l_sq), .o_epc_we(l_we), .o_epc(l_epc),
    .o_irq_ack(l_ack), .o_in_handler(l_inh), .o_dbl_fault(l_dbl), .o_trap_cnt(l_cnt)
  );

  function automatic vec_t mk(input logic lvl, input logic rst, input logic st,
                              input logic [2:0] c, input logic kk, input logic [31:0] p,
                              input logic ir, input logic [2:0] src, input logic sq,
                              input logic we, input logic [31:0] epc, input logic ack,
                              input logic inh, input logic dbl, input logic [15:0] cnt);
    vec_t v;
    v.lvl = lvl; v.rst = rst; v.stall = st; v.cls = c; v.k = kk; v.pc = p; v.irq = ir;
    v.src = src; v.sq = sq; v.we = we; v.epc = epc; v.ack = ack;
    v.inh = inh; v.dbl = dbl; v.cnt = cnt;
    return v;
  endfunction

  // Scoreboard checker: compares the oldest outstanding vector mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t        e;
      logic [2:0]  a_src;
      logic        a_sq, a_we, a_ack, a_inh, a_dbl;
      logic [31:0] a_epc;
      logic [15:0] a_cnt;
      logic        bad;
      e = sb.pop_front();
      if (e.lvl) begin
        a_src = l_src; a_sq = l_sq; a_we = l_we; a_epc = l_epc; a_ack = l_ack;
        a_inh = l_inh; a_dbl = l_dbl; a_cnt = {14'd0, l_cnt};
      end else begin
        a_src = e_src; a_sq = e_sq; a_we = e_we; a_epc = e_epc; a_ack = e_ack;
        a_inh = e_inh; a_dbl = e_dbl; a_cnt = e_cnt;
      end
      bad = (a_src !== e.src) || (a_sq !== e.sq) || (a_we !== e.we) || (a_ack !== e.ack) ||
            (a_inh !== e.inh) || (a_dbl !== e.dbl) || (a_cnt !== e.cnt) ||
            (e.we && (a_epc !== e.epc));
      n_vec++;
      if (bad) begin
        n_miss++;
        $display("FAIL vec%0d %s: got src=%b sq=%b we=%b epc=%h ack=%b inh=%b dbl=%b cnt=%0d; want src=%b sq=%b we=%b epc=%h ack=%b inh=%b dbl=%b cnt=%0d",
                 n_idx, e.lvl ? "level" : "edge", a_src, a_sq, a_we, a_epc, a_ack, a_inh, a_dbl, a_cnt,
                 e.src, e.sq, e.we, e.epc, e.ack, e.inh, e.dbl, e.cnt);
      end else begin
        $display("vec%0d %s ok: cls=%0d pc=%h src=%b epc_we=%b inh=%b cnt=%0d",
                 n_idx, e.lvl ? "level" : "edge", e.cls, e.pc, a_src, a_we, a_inh, a_cnt);
      end
      n_idx++;
    end
  end

  task automatic drive(input vec_t v);
    @(posedge clk);
    #1;
    reset = v.rst; stall = v.stall; cls = v.cls; k = v.k; pc = v.pc; irq = v.irq;
    sb.push_back(v);
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      reset = 1'b0; stall = 1'b0; cls = SEQ; k = 1'b0; pc = 32'd0; irq = 1'b0;
    end
  endtask

  initial begin
    // Edge-mode instance: flow classes, interrupt latency, pending hold,
    // ILLOP priority, epc wrap, double fault, stall, reset mid-handler.
    //           L  R  S  cls  k  pc            irq src   sq we epc           ack inh dbl cnt
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000040, 0, 3'b000, 0, 0, 32'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, BR,  0, 32'h00000044, 0, 3'b001, 0, 0, 32'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, JMP, 0, 32'h00000048, 0, 3'b010, 0, 0, 32'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, JR,  0, 32'h0000004C, 0, 3'b011, 0, 0, 32'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, OTH, 0, 32'h00000050, 0, 3'b000, 0, 0, 32'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000040, 1, 3'b000, 0, 0, 32'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000040, 0, 3'b000, 0, 0, 32'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000040, 0, 3'b000, 0, 0, 32'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000040, 0, 3'b101, 1, 1, 32'h00000040, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000044, 1, 3'b000, 0, 0, 32'h0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000048, 0, 3'b000, 0, 0, 32'h0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h0000004C, 0, 3'b000, 0, 0, 32'h0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000050, 0, 3'b000, 0, 0, 32'h0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, JR,  1, 32'h00000054, 0, 3'b011, 0, 0, 32'h0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, JR,  0, 32'h00000058, 0, 3'b011, 0, 0, 32'h0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000200, 0, 3'b101, 1, 1, 32'h00000200, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, JR,  0, 32'h00000204, 0, 3'b011, 0, 0, 32'h0, 0, 1, 0, 2));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000200, 0, 3'b000, 0, 0, 32'h0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000100, 1, 3'b000, 0, 0, 32'h0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000100, 0, 3'b000, 0, 0, 32'h0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000100, 0, 3'b000, 0, 0, 32'h0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, ILL, 0, 32'h00000100, 0, 3'b100, 1, 1, 32'h00000104, 0, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h80000000, 0, 3'b000, 0, 0, 32'h0, 0, 1, 0, 3));
    tbl.push_back(mk(0, 1, 0, JR,  0, 32'h80000004, 0, 3'b011, 0, 0, 32'h0, 0, 1, 0, 3));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h80000010, 0, 3'b000, 0, 0, 32'h0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000300, 0, 3'b101, 1, 1, 32'h00000300, 1, 0, 0, 3));
    tbl.push_back(mk(0, 1, 0, JR,  0, 32'h00000304, 0, 3'b011, 0, 0, 32'h0, 0, 1, 0, 4));
    tbl.push_back(mk(0, 1, 0, ILL, 0, 32'h7FFFFFFC, 0, 3'b100, 1, 1, 32'h00000000, 0, 0, 0, 4));
    tbl.push_back(mk(0, 1, 0, ILL, 0, 32'h00000010, 0, 3'b100, 1, 1, 32'h00000014, 0, 1, 0, 5));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000014, 0, 3'b000, 0, 0, 32'h0, 0, 1, 1, 6));
    tbl.push_back(mk(0, 1, 0, JR,  0, 32'h00000018, 0, 3'b011, 0, 0, 32'h0, 0, 1, 1, 6));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000020, 0, 3'b000, 0, 0, 32'h0, 0, 0, 1, 6));
    tbl.push_back(mk(0, 1, 0, ILL, 0, 32'hFFFFFFFC, 0, 3'b100, 1, 1, 32'h80000000, 0, 0, 1, 6));
    tbl.push_back(mk(0, 1, 0, JR,  0, 32'h80000000, 0, 3'b011, 0, 0, 32'h0, 0, 1, 1, 7));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000400, 1, 3'b000, 0, 0, 32'h0, 0, 0, 1, 7));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000400, 0, 3'b000, 0, 0, 32'h0, 0, 0, 1, 7));
    tbl.push_back(mk(0, 1, 1, SEQ, 0, 32'h00000400, 0, 3'b111, 0, 0, 32'h0, 0, 0, 1, 7));
    tbl.push_back(mk(0, 1, 1, ILL, 0, 32'h00000400, 0, 3'b111, 0, 0, 32'h0, 0, 0, 1, 7));
    tbl.push_back(mk(0, 1, 0, ILL, 0, 32'h00000400, 0, 3'b100, 1, 1, 32'h00000404, 0, 0, 1, 7));
    tbl.push_back(mk(0, 1, 0, JR,  0, 32'h00000404, 0, 3'b011, 0, 0, 32'h0, 0, 1, 1, 8));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000500, 0, 3'b101, 1, 1, 32'h00000500, 1, 0, 1, 8));
    tbl.push_back(mk(0, 1, 1, JR,  0, 32'h00000504, 1, 3'b111, 0, 0, 32'h0, 0, 1, 1, 9));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000504, 0, 3'b000, 0, 0, 32'h0, 0, 1, 1, 9));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000508, 0, 3'b000, 0, 0, 32'h0, 0, 1, 1, 9));
    tbl.push_back(mk(0, 0, 0, ILL, 0, 32'h00000020, 0, 3'b100, 1, 1, 32'h00000024, 0, 1, 1, 9));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000000, 0, 3'b000, 0, 0, 32'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000004, 0, 3'b000, 0, 0, 32'h0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, SEQ, 0, 32'h00000008, 0, 3'b000, 0, 0, 32'h0, 0, 0, 0, 0));

    reset_cycles(3);
    for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);

    // Level-mode instance: 2-cycle latency, re-entry right after return,
    // counter saturation at 3, reset clearing state.
    reset_cycles(3);
    drive(mk(1, 1, 0, SEQ, 0, 32'h00000040, 1, 3'b000, 0, 0, 32'h0, 0, 0, 0, 0));
    drive(mk(1, 1, 0, SEQ, 0, 32'h00000040, 1, 3'b000, 0, 0, 32'h0, 0, 0, 0, 0));
    drive(mk(1, 1, 0, SEQ, 0, 32'h00000040, 1, 3'b101, 1, 1, 32'h00000040, 1, 0, 0, 0));
    drive(mk(1, 1, 0, SEQ, 0, 32'h00000044, 1, 3'b000, 0, 0, 32'h0, 0, 1, 0, 1));
    drive(mk(1, 1, 0, JR,  0, 32'h00000048, 1, 3'b011, 0, 0, 32'h0, 0, 1, 0, 1));
    drive(mk(1, 1, 0, SEQ, 0, 32'h00000048, 0, 3'b101, 1, 1, 32'h00000048, 1, 0, 0, 1));
    drive(mk(1, 1, 0, JR,  0, 32'h0000004C, 0, 3'b011, 0, 0, 32'h0, 0, 1, 0, 2));
    drive(mk(1, 1, 0, SEQ, 0, 32'h00000050, 0, 3'b000, 0, 0, 32'h0, 0, 0, 0, 2));
    drive(mk(1, 1, 0, ILL, 0, 32'h00000000, 0, 3'b100, 1, 1, 32'h00000004, 0, 0, 0, 2));
    drive(mk(1, 1, 0, ILL, 0, 32'h00000008, 0, 3'b100, 1, 1, 32'h0000000C, 0, 1, 0, 3));
    drive(mk(1, 1, 0, ILL, 0, 32'h00000008, 0, 3'b100, 1, 1, 32'h0000000C, 0, 1, 1, 3));
    drive(mk(1, 1, 0, ILL, 0, 32'h00000008, 0, 3'b100, 1, 1, 32'h0000000C, 0, 1, 1, 3));
    drive(mk(1, 1, 0, SEQ, 0, 32'h00000010, 0, 3'b000, 0, 0, 32'h0, 0, 1, 1, 3));
    drive(mk(1, 0, 0, SEQ, 0, 32'h00000014, 0, 3'b000, 0, 0, 32'h0, 0, 1, 1, 3));
    drive(mk(1, 1, 0, SEQ, 0, 32'h00000018, 0, 3'b000, 0, 0, 32'h0, 0, 0, 0, 0));

    // Let the checker drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #6;
    if (sb.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d vectors left unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pc_seq_ctrl.md
# pc_seq_ctrl

Sequencing controller for the PC update unit of the single-cycle core. Each cycle it arbitrates between normal instruction flow, stalls, illegal-opcode traps and external interrupts, and drives the PC unit's 3-bit source select. It also produces the exception-return address write (EPC into $26), the squash of the current instruction, and a handler-mode state machine that masks nested interrupts. It sits between the instruction decoder and the PC unit.

## Interface
- IRQ_EDGE, 1: 1 = interrupt is rising-edge triggered and latched as pending; 0 = level (pending = synchronised level)
- CNT_W, 16: width of the saturating trap counter
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- stall  in  1  datapath wait; hold the PC this cycle
- instr_class  in  3  decoded class: 0 SEQ, 1 BRANCH, 2 JUMP, 3 JR, 7 ILLEGAL, others treated as SEQ
- jr_tgt_k  in  1  bit 31 of the JR target register (A[31])
- pc  in  32  current PC
- irq  in  1  asynchronous external interrupt request
- pc_src  out  3  PC unit select: 000 plus4, 001 branch, 010 jump, 011 jr, 100 ILLOP, 101 XADR, 111 hold
- squash  out  1  suppress register/memory writes of the current instruction
- epc_we  out  1  write epc into $26 at this clock edge
- epc  out  32  exception return address
- irq_ack  out  1  one-cycle pulse when an interrupt is taken
- in_handler  out  1  FSM is in HANDLER
- dbl_fault  out  1  sticky; illegal opcode taken while in HANDLER
- trap_cnt  out  CNT_W  saturating count of taken traps (ILLOP + XADR)

## Operation
- irq passes through a 2-flop synchroniser (irq_s). Edge mode: a rising edge of irq_s sets `pend`. Level mode: `pend` = irq_s.
- irq_ok = pend & ~pc[31] & ~in_handler.
- Priority is evaluated combinationally each cycle, highest first:
  1. stall: pc_src=111, squash=0, epc_we=0. No state changes, except that the synchroniser and the edge latch keep running.
  2. instr_class==ILLEGAL: pc_src=100, squash=1, epc_we=1, epc={pc[31], pc[30:0]+4}.
  3. irq_ok: pc_src=101, squash=1, epc_we=1, epc=pc (the instruction is re-executed on return), irq_ack=1.
  4. Otherwise pc_src follows instr_class: SEQ 000, BRANCH 001, JUMP 010, JR 011. squash=0, epc_we=0.
- An illegal opcode therefore wins over a simultaneous interrupt. The interrupt stays pending and is taken later.
- FSM states:
  - NORMAL → HANDLER on any taken trap.
  - HANDLER → NORMAL on an unstalled JR with jr_tgt_k=0 (exception return).
  - An ILLEGAL taken while in HANDLER sets dbl_fault; the FSM stays in HANDLER.
- Edge mode, pending clear: an interrupt take clears pend. If a new rising edge arrives in the same cycle as the take, pend stays set.
- trap_cnt increments on each taken trap and saturates at all-ones.
- in_handler = (state==HANDLER).

## Timing
- pc_src, squash, epc_we, epc and irq_ack are combinational from the registered state and the current inputs. They take effect at the same clk edge as the PC update (zero latency).
- State, pend, dbl_fault and trap_cnt update on the rising clk edge.
- Interrupt latency, from irq going high to the first cycle in which XADR can be selected:
  - edge mode: 3 cycles
  - level mode: 2 cycles
- Reset values (applied while reset=0 at a clock edge): state NORMAL, pend 0, synchroniser 0, dbl_fault 0, trap_cnt 0.
- During reset, combinational outputs still follow the inputs, with irq_ok forced to 0. The PC unit itself ignores pc_src during reset.
- If reset is asserted mid-handler, the block returns to NORMAL and a pending interrupt is lost.
- In level mode, an irq still high after the return re-enters the handler 1 cycle after the return.

## Test plan
- Reset, then SEQ/BRANCH/JUMP/JR classes with no irq → pc_src 000/001/010/011; squash=0; epc_we=0; trap_cnt=0.
- IRQ_EDGE=1, pc=0x00000040, irq pulse 1 cycle, class SEQ → 3 cycles later pc_src=101, epc=0x00000040, irq_ack=1, in_handler=1 next cycle; a second pulse during the handler is held pending. It is taken right after JR with jr_tgt_k=0.
- Same cycle ILLEGAL and pending irq, pc=0x00000100 → pc_src=100, epc=0x00000104; the following SEQ cycle with pc[31]=1 gives no XADR. The irq is taken after the handler returns.
- ILLEGAL with pc=0x7FFFFFFC → epc=0x00000000 (bit 31 preserved, low 31 bits wrap); ILLEGAL again while in HANDLER → dbl_fault=1 and stays 1 until reset.
- stall=1 together with pending irq and ILLEGAL → pc_src=111, no epc_we, state unchanged; on stall release the ILLOP is taken first.
- CNT_W=2, 5 traps → trap_cnt saturates at 3; reset asserted while in HANDLER → state NORMAL, pend 0, trap_cnt 0.
